pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the number of IMEM_WAIT cycles before err_timeout_o sets.
REQ-002 SHALL have parameter WAIT_W, default 8, the width of the wait counter; TIMEOUT SHALL fit in WAIT_W bits.
REQ-003 clk_i  in  1  clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs_i, id_rt_i  in  3 each  source register fields of the instruction held in IF/ID.
REQ-006 id_uses_rs_i, id_uses_rt_i  in  1 each  the ID instruction reads rs / rt.
REQ-007 ex_memread_i  in  1  the instruction in EX is a load.
REQ-008 ex_rd_i  in  3  destination register of the instruction in EX.
REQ-009 ex_branch_taken_i  in  1  branch resolved taken in EX.
REQ-010 imem_ready_i  in  1  instruction memory returns a valid 16-bit word this cycle.
REQ-011 pc_write_o  out  1  PC register load enable.
REQ-012 ifid_write_o  out  1  IF/ID load enable.
REQ-013 ifid_flush_o  out  1  IF/ID loads 0 (NOP) instead of the fetched instruction.
REQ-014 idex_bubble_o  out  1  ID/EX loads control zeros.
REQ-015 state_o  out  2  current state encoding.
REQ-016 stall_cnt_o  out  16  saturating stall-cycle count.
REQ-017 err_timeout_o  out  1  sticky instruction-fetch timeout flag.

Function
REQ-018 SHALL implement FSM states IDLE=0, RUN=1, LU_STALL=2, IMEM_WAIT=3; all four outputs derive combinationally from state and current inputs.
REQ-019 Load-use hazard SHALL be ex_memread_i & (ex_rd_i!=0) & ((id_uses_rs_i & id_rs_i==ex_rd_i) | (id_uses_rt_i & id_rt_i==ex_rd_i)); r0 never creates a hazard.
REQ-020 IDLE SHALL drive pc_write_o=0, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1, then go to RUN unconditionally.
REQ-021 RUN priority SHALL be branch > fetch-not-ready > load-use > normal.
REQ-022 RUN with ex_branch_taken_i=1 SHALL drive pc_write_o=1, ifid_write_o=1, ifid_flush_o=1, idex_bubble_o=1 and stay in RUN, regardless of other inputs.
REQ-023 RUN with imem_ready_i=0 SHALL drive pc_write_o=0, ifid_write_o=0, ifid_flush_o=0, idex_bubble_o=1 and go to IMEM_WAIT.
REQ-024 RUN with a load-use hazard SHALL drive pc_write_o=0, ifid_write_o=0, idex_bubble_o=1 and go to LU_STALL; the pipeline has no MEM-to-EX forwarding, so the load-use penalty is 2 bubbles.
REQ-025 RUN normal SHALL drive pc_write_o=1, ifid_write_o=1, ifid_flush_o=0, idex_bubble_o=0.
REQ-026 LU_STALL SHALL repeat the freeze-plus-bubble outputs for exactly one cycle, then go to RUN; ex_branch_taken_i here SHALL apply REQ-022 outputs and go to RUN.
REQ-027 IMEM_WAIT SHALL hold freeze-plus-bubble while imem_ready_i=0; imem_ready_i=1 SHALL drive normal outputs (REQ-025) and go to RUN.
REQ-028 IMEM_WAIT with ex_branch_taken_i=1 SHALL apply REQ-022 outputs and go to RUN, overriding imem_ready_i.
REQ-029 Wait counter (WAIT_W bits) SHALL clear on entry to IMEM_WAIT and increment each IMEM_WAIT cycle; reaching TIMEOUT SHALL set err_timeout_o until reset, and the FSM keeps waiting.
REQ-030 stall_cnt_o SHALL increment by 1 on each cycle with pc_write_o=0 in states other than IDLE, and SHALL saturate at 0xFFFF without wrapping.

Reset
REQ-031 rst_n low SHALL asynchronously force state IDLE, stall_cnt_o=0, wait counter=0, err_timeout_o=0; reset mid-stall SHALL abandon the stall.
REQ-032 On the first rising edge after rst_n deasserts, the FSM SHALL leave IDLE, giving exactly one IDLE cycle.

Structure
REQ-033 Shared package pipe_ctrl_pkg SHALL hold the state enum, REG_W=3, INSTR_W=16 and STALL_CNT_W=16.
REQ-034 SHALL instantiate one combinational sub-module, hazard_detect, which computes the REQ-019 term.

Verification
REQ-035 Load r3 in EX, ID reads rs=3 -> 2 cycles pc_write_o=0/idex_bubble_o=1 (states RUN->LU_STALL->RUN), stall_cnt_o +2.
REQ-036 Load with ex_rd_i=0, ID rs=0 -> no stall, pc_write_o=1 every cycle.
REQ-037 Branch taken and load-use hazard in the same cycle -> ifid_flush_o=1, pc_write_o=1, state stays RUN.
REQ-038 imem_ready_i low 5 cycles -> 5 freeze cycles, exit on ready with pc_write_o=1; with TIMEOUT=4, err_timeout_o=1 and stays 1 after ready.
REQ-039 stall_cnt_o preloaded near 0xFFFE plus 3 stall cycles -> reads 0xFFFF.
REQ-040 rst_n pulsed low during IMEM_WAIT -> immediate IDLE, all counters 0, err_timeout_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
// State encoding, register field width, instruction and counter widths.
package pipe_ctrl_pkg;
  localparam int REG_W       = 3;
  localparam int INSTR_W     = 16;
  localparam int STALL_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LU_STALL  = 2'd2,
    IMEM_WAIT = 2'd3
  } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives hazard inputs); slave: controller.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0]       id_rs_i;
  logic [REG_W-1:0]       id_rt_i;
  logic                   id_uses_rs_i;
  logic                   id_uses_rt_i;
  logic                   ex_memread_i;
  logic [REG_W-1:0]       ex_rd_i;
  logic                   ex_branch_taken_i;
  logic                   imem_ready_i;
  logic                   pc_write_o;
  logic                   ifid_write_o;
  logic                   ifid_flush_o;
  logic                   idex_bubble_o;
  logic [1:0]             state_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  logic                   err_timeout_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
    output ex_memread_i, ex_rd_i, ex_branch_taken_i,
    output imem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o,
    input  idex_bubble_o, state_o, stall_cnt_o,
    input  err_timeout_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rs_i, id_uses_rt_i,
    input  ex_memread_i, ex_rd_i, ex_branch_taken_i,
    input  imem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o,
    output idex_bubble_o, state_o, stall_cnt_o,
    output err_timeout_o
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard term: EX load writes a register the ID instr reads.
// Ports: ID source fields/uses, EX memread/rd in; hazard_o out. r0 exempt.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rd_i,
  output logic             hazard_o
);
  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs_i & (id_rs_i == ex_rd_i);
  assign rt_hit = id_uses_rt_i & (id_rt_i == ex_rd_i);

  assign hazard_o = ex_memread_i & (ex_rd_i != '0)
                  & (rs_hit | rt_hit);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, branch and fetch-wait.
// Ports: clk_i, rst_n (async low), bus (slave: hazard in, controls out).
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int WAIT_W  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  pipe_hazard_ctrl_if.slave    bus
);
  localparam logic [WAIT_W-1:0] TO    = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] TO_M1 = WAIT_W'(TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  state_e                 state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic hazard;
  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble;

  hazard_detect u_hazard_detect (
    .id_rs_i      (bus.id_rs_i),
    .id_rt_i      (bus.id_rt_i),
    .id_uses_rs_i (bus.id_uses_rs_i),
    .id_uses_rt_i (bus.id_uses_rt_i),
    .ex_memread_i (bus.ex_memread_i),
    .ex_rd_i      (bus.ex_rd_i),
    .hazard_o     (hazard)
  );

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    unique case (state_q)
      IDLE: begin
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (bus.ex_branch_taken_i) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end else if (!bus.imem_ready_i) begin
          state_d = IMEM_WAIT;
        end else if (hazard) begin
          state_d = LU_STALL;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b0;
        end
      end
      LU_STALL: begin
        // Second bubble: no MEM-to-EX forwarding path exists.
        state_d = RUN;
        if (bus.ex_branch_taken_i) begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end
      end
      IMEM_WAIT: begin
        if (bus.ex_branch_taken_i) begin
          state_d    = RUN;
          pc_write   = 1'b1;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end else if (bus.imem_ready_i) begin
          state_d     = RUN;
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_bubble = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    if (state_q == RUN && state_d == IMEM_WAIT) begin
      wait_d = '0;
    end else if (state_q == IMEM_WAIT) begin
      // Hold at TIMEOUT so a long wait cannot wrap back.
      if (wait_q != TO) wait_d = wait_q + 1'b1;
      if (wait_q == TO_M1) err_d = 1'b1;
    end
    if (!pc_write && state_q != IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write_o    = pc_write;
  assign bus.ifid_write_o  = ifid_write;
  assign bus.ifid_flush_o  = ifid_flush;
  assign bus.idex_bubble_o = idex_bubble;
  assign bus.state_o       = state_q;
  assign bus.stall_cnt_o   = cnt_q;
  assign bus.err_timeout_o = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, state}.
module tb_pipe_hazard_ctrl;
  logic clk_i;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(
    .TIMEOUT (4),
    .WAIT_W  (8)
  ) dut (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [5:0] C_IDLE   = 6'b011100;
  localparam logic [5:0] C_RUN    = 6'b110001;
  localparam logic [5:0] C_RUN_BR = 6'b111101;
  localparam logic [5:0] C_RUN_FZ = 6'b000101;
  localparam logic [5:0] C_LU_FZ  = 6'b000110;
  localparam logic [5:0] C_LU_BR  = 6'b111110;
  localparam logic [5:0] C_IM_FZ  = 6'b000111;
  localparam logic [5:0] C_IM_RDY = 6'b110011;
  localparam logic [5:0] C_IM_BR  = 6'b111111;

  logic [5:0] ctl;
  assign ctl = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
                bus.idex_bubble_o, bus.state_o};

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    bus.id_rs_i           = '0;
    bus.id_rt_i           = '0;
    bus.id_uses_rs_i      = 1'b0;
    bus.id_uses_rt_i      = 1'b0;
    bus.ex_memread_i      = 1'b0;
    bus.ex_rd_i           = '0;
    bus.ex_branch_taken_i = 1'b0;
    bus.imem_ready_i      = 1'b1;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_in();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL rst_ctl got=%b exp=%b", ctl, C_IDLE);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== 16'd0 || bus.err_timeout_o !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_cnt got=%h/%b exp=0000/0",
               bus.stall_cnt_o, bus.err_timeout_o);
    end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL rst_hold got=%b exp=%b", ctl, C_IDLE);
    end
    tick();
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL rst_exit got=%b exp=%b", ctl, C_RUN);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_idle_cnt got=%h exp=0000", bus.stall_cnt_o);
    end
  endtask

  task automatic test_load_use();
    logic [15:0] s0;
    s0 = bus.stall_cnt_o;
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i      = 3'd3;
    bus.id_rs_i      = 3'd3;
    bus.id_uses_rs_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN_FZ) begin
      n_bad++;
      $display("FAIL lu_c1 got=%b exp=%b", ctl, C_RUN_FZ);
    end
    tick();
    idle_in();
    #1;
    n_cmp++;
    if (ctl !== C_LU_FZ) begin
      n_bad++;
      $display("FAIL lu_c2 got=%b exp=%b", ctl, C_LU_FZ);
    end
    tick();
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL lu_c3 got=%b exp=%b", ctl, C_RUN);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== s0 + 16'd2) begin
      n_bad++;
      $display("FAIL lu_cnt got=%h exp=%h", bus.stall_cnt_o, s0 + 16'd2);
    end
    // rt-only match stalls; rt match with uses_rt=0 does not
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i      = 3'd6;
    bus.id_rs_i      = 3'd6;
    bus.id_rt_i      = 3'd6;
    bus.id_uses_rs_i = 1'b0;
    bus.id_uses_rt_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_RUN_FZ) begin
      n_bad++;
      $display("FAIL lu_rt got=%b exp=%b", ctl, C_RUN_FZ);
    end
    bus.id_uses_rt_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL lu_nouse got=%b exp=%b", ctl, C_RUN);
    end
    idle_in();
    #1;
  endtask

  task automatic test_r0();
    logic [15:0] s0;
    s0 = bus.stall_cnt_o;
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i      = 3'd0;
    bus.id_rs_i      = 3'd0;
    bus.id_rt_i      = 3'd0;
    bus.id_uses_rs_i = 1'b1;
    bus.id_uses_rt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
        n_bad++;
        $display("FAIL r0_c%0d got=%b exp=%b", i, ctl, C_RUN);
      end
      tick();
    end
    n_cmp++;
    if (bus.stall_cnt_o !== s0) begin
      n_bad++;
      $display("FAIL r0_cnt got=%h exp=%h", bus.stall_cnt_o, s0);
    end
    idle_in();
  endtask

  task automatic test_branch();
    bus.ex_memread_i      = 1'b1;
    bus.ex_rd_i           = 3'd5;
    bus.id_rs_i           = 3'd5;
    bus.id_uses_rs_i      = 1'b1;
    bus.ex_branch_taken_i = 1'b1;
    bus.imem_ready_i      = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN_BR) begin
      n_bad++;
      $display("FAIL br_run got=%b exp=%b", ctl, C_RUN_BR);
    end
    tick();
    n_cmp++;
    if (bus.state_o !== 2'd1) begin
      n_bad++;
      $display("FAIL br_stay got=%0d exp=1", bus.state_o);
    end
    // branch while in LU_STALL
    bus.ex_branch_taken_i = 1'b0;
    bus.imem_ready_i      = 1'b1;
    tick();
    idle_in();
    bus.ex_branch_taken_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_LU_BR) begin
      n_bad++;
      $display("FAIL br_lu got=%b exp=%b", ctl, C_LU_BR);
    end
    tick();
    bus.ex_branch_taken_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL br_lu_exit got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_imem_wait();
    logic [15:0] s0;
    s0 = bus.stall_cnt_o;
    bus.imem_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_RUN_FZ) begin
      n_bad++;
      $display("FAIL im_run got=%b exp=%b", ctl, C_RUN_FZ);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_cmp++;
      if ({ctl, bus.err_timeout_o} !== {C_IM_FZ, 1'b0}) begin
        n_bad++;
        $display("FAIL im_w%0d got=%b/%b exp=%b/0",
                 i, ctl, bus.err_timeout_o, C_IM_FZ);
      end
    end
    tick();
    bus.imem_ready_i = 1'b1;
    #1;
    n_cmp++;
    if ({ctl, bus.err_timeout_o} !== {C_IM_RDY, 1'b1}) begin
      n_bad++;
      $display("FAIL im_rdy got=%b/%b exp=%b/1",
               ctl, bus.err_timeout_o, C_IM_RDY);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== s0 + 16'd5) begin
      n_bad++;
      $display("FAIL im_cnt got=%h exp=%h", bus.stall_cnt_o, s0 + 16'd5);
    end
    tick();
    tick();
    n_cmp++;
    if ({ctl, bus.err_timeout_o} !== {C_RUN, 1'b1}) begin
      n_bad++;
      $display("FAIL im_sticky got=%b/%b exp=%b/1",
               ctl, bus.err_timeout_o, C_RUN);
    end
    // branch overrides a pending fetch
    bus.imem_ready_i = 1'b0;
    tick();
    bus.ex_branch_taken_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== C_IM_BR) begin
      n_bad++;
      $display("FAIL im_br got=%b exp=%b", ctl, C_IM_BR);
    end
    tick();
    idle_in();
    #1;
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL im_br_exit got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_reset_mid();
    bus.imem_ready_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_IDLE) begin
      n_bad++;
      $display("FAIL rm_ctl got=%b exp=%b", ctl, C_IDLE);
    end
    n_cmp++;
    if (bus.stall_cnt_o !== 16'd0 || bus.err_timeout_o !== 1'b0
        || dut.wait_q !== 8'd0) begin
      n_bad++;
      $display("FAIL rm_cnt got=%h/%b/%h exp=0000/0/00",
               bus.stall_cnt_o, bus.err_timeout_o, dut.wait_q);
    end
    tick();
    rst_n = 1'b1;
    idle_in();
    tick();
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_bad++;
      $display("FAIL rm_exit got=%b exp=%b", ctl, C_RUN);
    end
  endtask

  task automatic test_stall_sat();
    do_reset();
    tick();
    bus.imem_ready_i = 1'b0;
    repeat (65534) tick();
    n_cmp++;
    if (bus.stall_cnt_o !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL sat_pre got=%h exp=fffe", bus.stall_cnt_o);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.stall_cnt_o !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL sat_end got=%h exp=ffff", bus.stall_cnt_o);
    end
    n_cmp++;
    if (ctl !== C_IM_FZ) begin
      n_bad++;
      $display("FAIL sat_ctl got=%b exp=%b", ctl, C_IM_FZ);
    end
    idle_in();
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_load_use();
    test_r0();
    test_branch();
    test_imem_wait();
    test_reset_mid();
    test_stall_sat();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
